// File: rtl/instr_encoder.sv
// RV32I instruction encoder for the program-loader path: latches a field bundle,
// encodes and checks it, then issues a single instruction-memory write.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrOpcode   = 2'b01;
  localparam logic [1:0] ErrRange    = 2'b10;
  localparam logic [1:0] ErrMisalign = 2'b11;

  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] Depth   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LastCnt = Depth - CntOne;

  typedef enum logic [1:0] {StIdle, StEnc, StWrite, StErr} state_e;
  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtBad} fmt_e;

  state_e      state_q;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] imm_q;
  logic [31:0] word_q;
  logic [1:0]  code_q;

  fmt_e        fmt;
  logic [2:0]  f3_eff;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        range_ok;
  logic        misalign;

  // Count never exceeds the depth, so its MSB alone means "full".
  assign full = count[ADDR_W];

  always_comb begin
    fmt = FmtBad;
    case (op_q)
      OpReg:                  fmt = FmtR;
      OpImm, OpLoad, OpJalr:  fmt = FmtI;
      OpStore:                fmt = FmtS;
      OpBranch:               fmt = FmtB;
      OpJal:                  fmt = FmtJ;
      OpLui, OpAuipc:         fmt = FmtU;
      default:                fmt = FmtBad;
    endcase

    f3_eff = (op_q == OpJalr) ? 3'b000 : f3_q;

    enc_word = '0;
    case (fmt)
      FmtR: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      FmtI: enc_word = {imm_q[11:0], rs1_q, f3_eff, rd_q, op_q};
      FmtS: enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      FmtB: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11],
                        op_q};
      FmtU: enc_word = {imm_q[31:12], rd_q, op_q};
      FmtJ: enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
      default: enc_word = '0;
    endcase

    // A value fits a signed field when all bits above the field's sign bit match it.
    range_ok = 1'b1;
    case (fmt)
      FmtI, FmtS: range_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
      FmtB:       range_ok = (&imm_q[31:12]) | ~(|imm_q[31:12]);
      FmtJ:       range_ok = (&imm_q[31:20]) | ~(|imm_q[31:20]);
      FmtU:       range_ok = (imm_q[11:0] == 12'h000);
      default:    range_ok = 1'b1;
    endcase

    misalign = ((fmt == FmtB) || (fmt == FmtJ)) && imm_q[0];

    if (fmt == FmtBad) begin
      enc_code = ErrOpcode;
    end else if (misalign) begin
      enc_code = ErrMisalign;
    end else if (!range_ok) begin
      enc_code = ErrRange;
    end else begin
      enc_code = ErrNone;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && in_valid && in_ready) begin
      op_q  <= op;
      f3_q  <= funct3;
      f7_q  <= funct7;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
    if (state_q == StEnc) begin
      word_q <= enc_word;
      code_q <= enc_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
      err_code   <= ErrNone;
    end else begin
      imem_we <= 1'b0;
      // The strobe is registered, so the count follows it one edge later.
      if (imem_we) begin
        count <= count + CntOne;
      end
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state_q  <= StEnc;
          end
        end
        StEnc: begin
          state_q <= (enc_code != ErrNone) ? StErr : StWrite;
        end
        StWrite: begin
          imem_we    <= 1'b1;
          imem_addr  <= count[ADDR_W-1:0];
          imem_wdata <= word_q;
          in_ready   <= (count != LastCnt);
          state_q    <= StIdle;
        end
        StErr: begin
          if (!err) begin
            err      <= 1'b1;
            err_code <= code_q;
          end
          in_ready <= ~full;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
